exe_wb_arbiter: RTL

//   Sits between the execution units (ALU, FPU, LSU, ...) and the writeback/ROB-complete ports.

---
 rtl/exe_wb_arbiter_pkg.sv | 26 ++
 rtl/exe_wb_arbiter_rr_pick_n.sv | 39 +++
 rtl/exe_wb_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/exe_wb_arbiter_pkg.sv
// Shared execution/writeback types and the common operation-order compare.
package exe_wb_arbiter_pkg;

    typedef struct packed {
        logic [15:0] opid;   // [15] = redirect valid
        logic [15:0] topid;  // oldest in-flight operation ID
    } red_bundle_t;

    typedef struct packed {
        logic [15:0] opid;   // [15] = result valid
        logic [63:0] data;
    } exe_bundle_t;

    // True when x is valid, a redirect is active, and x lies strictly after the
    // redirecting op in the wrapped ID window anchored at topid.
    function automatic logic opid_younger(red_bundle_t r, logic [15:0] x, int opsz);
        logic [15:0] mask;
        logic [16:0] dx;
        logic [16:0] dr;
        mask = 16'(opsz - 1);
        dx   = {1'b0, (x - r.topid) & mask};
        dr   = {1'b0, (r.opid - r.topid) & mask};
        return r.opid[15] & x[15] & (dx >= dr + 17'd1);
    endfunction

endpackage

// File: rtl/exe_wb_arbiter_rr_pick_n.sv
// Combinational round-robin picker: up to k one-hot grants in scan order from start.
module rr_pick_n #(
    parameter  int n  = 8,
    parameter  int k  = 2,
    localparam int PW = (n > 1) ? $clog2(n) : 1,
    localparam int KW = (k > 1) ? $clog2(k) : 1
) (
    input  logic [n-1:0]          req_i,
    input  logic [PW-1:0]         start_i,
    output logic [k-1:0][n-1:0]   gnt_o,
    output logic [k-1:0]          gnt_vld_o,
    output logic [PW-1:0]         last_o
);

    // Scan from start_i with wrap, handing grant slots out in order.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] pi;
        logic [KW:0]   cnt;
        gnt_o     = '0;
        gnt_vld_o = '0;
        last_o    = '0;
        cnt       = '0;
        idx       = 0;
        pi        = '0;
        for (int unsigned i = 0; i < n; i++) begin
            idx = int'(start_i) + i;
            if (idx >= int'(n)) idx = idx - int'(n);
            pi = PW'(idx);
            if (req_i[pi] && (int'(cnt) < k)) begin
                gnt_o[cnt[KW-1:0]][pi] = 1'b1;
                gnt_vld_o[cnt[KW-1:0]] = 1'b1;
                last_o                 = pi;
                cnt                    = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exe_wb_arbiter.sv
// Round-robin arbiter from execution units onto the writeback ports, with
// redirect squash filtering on candidates and on held writeback entries.
module exe_wb_arbiter
    import exe_wb_arbiter_pkg::*;
#(
    parameter int nsrc = 4,
    parameter int ewd  = 2,
    parameter int opsz = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  red_bundle_t redir,
    input  exe_bundle_t src_resp [nsrc][ewd],
    output logic        src_claim [nsrc][ewd],
    input  logic        wb_stall,
    output exe_bundle_t wb [ewd],
    output logic [31:0] ovf_cnt
);

    localparam int NS = nsrc * ewd;
    localparam int PW = (NS > 1) ? $clog2(NS) : 1;

    exe_bundle_t             flat [NS];
    logic [NS-1:0]           live;
    logic [NS-1:0]           dead;
    logic [NS-1:0]           req;
    logic [NS-1:0]           granted;
    logic [ewd-1:0][NS-1:0]  gnt;
    logic [ewd-1:0]          gnt_vld;
    logic [PW-1:0]           last;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    exe_bundle_t             wb_q [ewd];
    exe_bundle_t             wb_d [ewd];
    logic [31:0]             ovf_cnt_q, ovf_cnt_d;

    for (genvar s = 0; s < nsrc; s++) begin : g_src
        for (genvar e = 0; e < ewd; e++) begin : g_slot
            localparam int K = s * ewd + e;
            logic yng;
            assign flat[K]         = src_resp[s][e];
            assign yng             = opid_younger(redir, src_resp[s][e].opid, opsz);
            assign live[K]         = src_resp[s][e].opid[15] & ~yng;
            assign dead[K]         = src_resp[s][e].opid[15] & yng;
            // Squashed results are drained even though they never take a wb slot.
            assign src_claim[s][e] = ~wb_stall & (granted[K] | dead[K]);
        end
    end

    assign req = live & {NS{~wb_stall}};

    rr_pick_n #(.n(NS), .k(ewd)) u_pick (
        .req_i     (req),
        .start_i   (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .last_o    (last)
    );

    // Collapse per-slot one-hot grants into a per-candidate grant mask.
    always_comb begin
        granted = '0;
        for (int unsigned j = 0; j < ewd; j++) granted = granted | gnt[j];
    end

    // Next writeback contents: mux granted results in, or hold and re-filter on stall.
    always_comb begin
        for (int unsigned j = 0; j < ewd; j++) begin
            if (wb_stall) begin
                wb_d[j] = wb_q[j];
                if (opid_younger(redir, wb_q[j].opid, opsz)) wb_d[j].opid = '0;
            end else begin
                wb_d[j] = '0;
                for (int unsigned m = 0; m < NS; m++) begin
                    if (gnt[j][m]) wb_d[j] = flat[m];
                end
                if (opid_younger(redir, wb_d[j].opid, opsz)) wb_d[j] = '0;
            end
        end
    end

    // Pointer advance past the last grant and saturating overflow counting.
    always_comb begin
        int unsigned live_cnt;
        live_cnt = 0;
        for (int unsigned m = 0; m < NS; m++) begin
            if (live[m]) live_cnt++;
        end
        rr_ptr_d = rr_ptr_q;
        if (!wb_stall && gnt_vld[0]) begin
            rr_ptr_d = (last == PW'(NS - 1)) ? '0 : last + 1'b1;
        end
        ovf_cnt_d = ovf_cnt_q;
        if (!wb_stall && (live_cnt > int'(ewd)) && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < ewd; j++) wb_q[j] <= '0;
            rr_ptr_q  <= '0;
            ovf_cnt_q <= '0;
        end else begin
            for (int unsigned j = 0; j < ewd; j++) wb_q[j] <= wb_d[j];
            rr_ptr_q  <= rr_ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign wb      = wb_q;
    assign ovf_cnt = ovf_cnt_q;

endmodule
